// File: rtl/apb_master_if.sv
// APB requester: turns single-beat valid/ready commands into SETUP/ACCESS
// transfers and returns read data / error status on a held response port.
module apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  // Next-state and datapath capture for the transfer sequencer
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and captured-data registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus strobes decode directly from state so they drop on the reset edge
  always_comb begin
    cmd_ready   = (state_q == IDLE) && !preset;
    psel        = (state_q == SETUP) || (state_q == ACCESS);
    penable     = (state_q == ACCESS);
    rsp_valid   = (state_q == RESP);
    pwrite      = pwrite_q;
    paddr       = paddr_q;
    pwdata      = pwdata_q;
    rsp_rdata   = rsp_rdata_q;
    rsp_err     = rsp_err_q;
    rsp_timeout = rsp_timeout_q;
  end

endmodule

// File: tb/tb_apb_master_if.sv
// Scoreboard bench for apb_master_if: a transfer-level model predicts each
// response, a bus-side slave answers with per-transfer wait counts, and an
// independent monitor checks bus protocol and pops/compares responses.
module tb_apb_master_if;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_master_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
    int         lat;
  } exp_t;

  exp_t       expq[$];
  int         wq[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         rst_seen = 1'b0;
  bit         hold_low = 1'b0;
  logic [7:0] model_mem [16];
  logic [7:0] slave_mem [16];

  always @(posedge pclk) begin
    cyc      <= cyc + 1;
    rst_seen <= preset;
  end

  function automatic void chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void chk8(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Response handshake driver: random backpressure unless held low
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // APB slave: 16 x 8 memory, pslverr above 0xF, wait count per transfer from wq
  initial begin
    int acc_cnt;
    int cur_wait;
    acc_cnt  = 0;
    cur_wait = 0;
    pready   = 1'b0;
    prdata   = '0;
    pslverr  = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        cur_wait = (wq.size() > 0) ? wq.pop_front() : 0;
        acc_cnt  = 0;
      end
      if (psel && penable) begin
        if (acc_cnt >= cur_wait) begin
          pready = 1'b1;
          if (paddr < 32'd16) begin
            pslverr = 1'b0;
            if (pwrite) begin
              slave_mem[paddr[3:0]] = pwdata;
              prdata = 8'($urandom);
            end else begin
              prdata = slave_mem[paddr[3:0]];
            end
          end else begin
            pslverr = 1'b1;
            prdata  = 8'($urandom);
          end
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom_range(0, 1));
          prdata  = 8'($urandom);
        end
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = 8'($urandom);
      end
    end
  end

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge
  initial begin
    logic [31:0] c_addr;
    logic        c_write;
    logic [7:0]  c_wdata;
    int          acc_cyc;
    bit          prev_access;
    bit          prev_hold;
    logic [7:0]  h_rdata;
    logic        h_err;
    logic        h_tmo;
    exp_t        e;
    c_addr = '0; c_write = 1'b0; c_wdata = '0; acc_cyc = 0;
    prev_access = 1'b0; prev_hold = 1'b0;
    h_rdata = '0; h_err = 1'b0; h_tmo = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset) chk1("cmd_ready_in_reset", cmd_ready, 1'b0);
      if (rst_seen) begin
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_pwrite", pwrite, 1'b0);
        chk32("rst_paddr", paddr, 32'h0);
        chk8("rst_pwdata", pwdata, 8'h0);
        chk8("rst_rsp_rdata", rsp_rdata, 8'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
        prev_access = 1'b0;
        prev_hold   = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          c_addr  = cmd_addr;
          c_write = cmd_write;
          c_wdata = cmd_wdata;
          acc_cyc = cyc;
        end
        chk1("penable_without_psel", penable && !psel, 1'b0);
        if (psel && !penable) chki("setup_cycle", cyc - acc_cyc, 1);
        if (psel && penable && !prev_access) chki("access_start", cyc - acc_cyc, 2);
        if (psel) begin
          chk32("paddr_stable", paddr, c_addr);
          chk1("pwrite_stable", pwrite, c_write);
          chk8("pwdata_stable", pwdata, c_write ? c_wdata : 8'h0);
        end
        if (rsp_valid) begin
          chk1("psel_in_resp", psel, 1'b0);
          chk1("cmd_ready_in_resp", cmd_ready, 1'b0);
          if (!prev_hold) begin
            if (expq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
              e = expq.pop_front();
              chk8("rsp_rdata", rsp_rdata, e.rdata);
              chk1("rsp_err", rsp_err, e.err);
              chk1("rsp_timeout", rsp_timeout, e.tmo);
              chki("rsp_latency", cyc - acc_cyc, e.lat);
            end
            h_rdata = rsp_rdata;
            h_err   = rsp_err;
            h_tmo   = rsp_timeout;
          end else begin
            chk8("hold_rdata", rsp_rdata, h_rdata);
            chk1("hold_err", rsp_err, h_err);
            chk1("hold_timeout", rsp_timeout, h_tmo);
          end
        end
        prev_access = psel && penable;
        prev_hold   = rsp_valid && !rsp_ready;
      end
    end
  end

  // Issue one command; expected response comes from the transfer-level model.
  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] d,
                       input int waits, input bit expect_rsp);
    exp_t e;
    int   n;
    if (expect_rsp) begin
      if (waits >= int'(TO)) begin
        e.rdata = 8'h0; e.err = 1'b1; e.tmo = 1'b1; e.lat = 2 + int'(TO);
      end else begin
        e.tmo = 1'b0;
        e.lat = 3 + waits;
        if (a >= 32'd16) begin
          e.err = 1'b1; e.rdata = 8'h0;
        end else begin
          e.err = 1'b0;
          if (w) begin
            model_mem[a[3:0]] = d;
            e.rdata = 8'h0;
          end else begin
            e.rdata = model_mem[a[3:0]];
          end
        end
      end
      expq.push_back(e);
    end
    wq.push_back(waits);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!cmd_ready && n < 300);
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 300 cycles");
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || rsp_valid) && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0 within 1000 cycles", expq.size());
    end
    @(posedge pclk);
    #1;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int n;
    logic [7:0] v;
    preset    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h3;
    cmd_wdata = 8'h55;
    for (int unsigned i = 0; i < 16; i++) begin
      v = 8'($urandom);
      model_mem[i] = v;
      slave_mem[i] = v;
    end
    repeat (2) @(posedge pclk);
    #1;
    preset    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk1("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(posedge pclk);
    #1;

    issue(1'b1, 32'h5, 8'hA7, 0, 1'b1);
    issue(1'b0, 32'h5, 8'h00, 0, 1'b1);
    issue(1'b1, 32'h10, 8'h33, 0, 1'b1);
    issue(1'b0, 32'h10, 8'h00, 0, 1'b1);
    issue(1'b0, 32'h2, 8'h00, 3, 1'b1);
    issue(1'b0, 32'h4, 8'h00, 255, 1'b1);
    issue(1'b0, 32'h6, 8'h00, int'(TO) - 1, 1'b1);
    issue(1'b1, 32'h7, 8'h5C, int'(TO), 1'b1);
    issue(1'b0, 32'h7, 8'h00, 0, 1'b1);
    drain();

    hold_low = 1'b1;
    issue(1'b0, 32'h5, 8'h00, 0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    repeat (5) begin
      @(negedge pclk);
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge pclk);
    #1;
    hold_low = 1'b0;
    drain();

    issue(1'b0, 32'h2, 8'h00, 255, 1'b0);
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!(psel && penable) && n < 20);
    chk1("reached_access", psel && penable, 1'b1);
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk1("post_rst_psel", psel, 1'b0);
    chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
    repeat (4) @(posedge pclk);
    #1;

    for (int k = 0; k < 60; k++) begin
      logic        w;
      logic [31:0] a;
      int          wt;
      int          r;
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = 32'($urandom_range(0, 15));
      else if (r == 8) a = 32'($urandom_range(16, 31));
      else             a = $urandom;
      if ($urandom_range(0, 9) == 0) wt = int'($urandom_range(TO - 1, TO + 4));
      else                           wt = int'($urandom_range(0, 4));
      issue(w, a, 8'($urandom), wt, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge pclk);
        #1;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_if.md
Name: apb_master_if

Overview:
- APB requester that drives the APB slave-side bus signals (psel, penable, paddr, pwrite, pwdata) and collects prdata, pready and pslverr.
- Converts single-beat commands from a local valid/ready command port into compliant SETUP/ACCESS transfers.
- Returns read data and error status on a held response port.
- Sits between the test/stimulus logic or a CPU-side agent and the 16-entry x 8-bit APB slave memory block.

Parameters:
- ADDR_WIDTH, 32, width of paddr and cmd_addr.
- DATA_WIDTH, 8, width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum number of ACCESS cycles waited for pready before the transfer is aborted (legal range 2..255).

Ports:
- pclk  in  1  bus clock; all logic on its rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  pslverr sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted because pready never arrived.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB slave ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Clocking and reset: single clock pclk; reset preset is synchronous and active-high.
- Reset values: state = IDLE, wait counter = 0. All outputs are 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout. cmd_ready is 0 while preset is high.
- Reset mid-operation: on the edge where preset is sampled high, the FSM returns to IDLE regardless of state, and psel/penable drop on that same edge. Any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 (combinational: state == IDLE && !preset).
  - On cmd_valid: capture cmd_write, cmd_addr and cmd_wdata into registers driving pwrite/paddr/pwdata, then go to SETUP.
  - For reads, pwdata is driven 0.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; then go to ACCESS.
- ACCESS: psel = 1, penable = 1. paddr, pwrite and pwdata are held stable from SETUP through the end of ACCESS. The wait counter increments every ACCESS cycle in which pready = 0.
  - On pready = 1:
    - rsp_rdata = read ? prdata : 0.
    - rsp_err = pslverr.
    - rsp_timeout = 0.
    - On error, rsp_rdata = 0 regardless of prdata.
    - Go to RESP.
  - If pready = 0 and the counter reaches TIMEOUT-1: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
  - pslverr is ignored in every cycle except the completing one (pready = 1).
- RESP:
  - psel = 0, penable = 0, rsp_valid = 1.
  - rsp_rdata, rsp_err and rsp_timeout are held stable.
  - On rsp_ready: rsp_valid drops next cycle and the FSM goes to IDLE.
  - rsp_valid and rsp_ready both high in the first RESP cycle is legal (single-cycle response).
  - cmd_ready = 0 while in RESP. A new command waiting in RESP is accepted in the following IDLE cycle.
- Latency:
  - Zero-wait slave: cmd accept (cycle 0) -> SETUP (1) -> ACCESS (2) -> rsp_valid (3).
  - Each slave wait state adds 1 cycle.
  - Minimum issue interval is 4 cycles with rsp_ready tied high.
- psel is never 1 outside SETUP/ACCESS.
- penable is high only in ACCESS.
- Only one transfer is outstanding at a time; there is no pipelining.

Test Plan:
- Reset: hold preset = 1 for 2 cycles with cmd_valid = 1 -> cmd_ready = 0, psel = 0, penable = 0, rsp_valid = 0; no transfer starts.
- Write then read: write addr 0x5 data 0xA7, then read addr 0x5 against a zero-wait slave -> read rsp_rdata = 0xA7 and rsp_err = 0 on both. On the read, psel rises 1 cycle after accept, penable 1 cycle later, and rsp_valid appears 3 cycles after accept.
- Out-of-range address: write addr 0x10 data 0x33 -> slave pslverr = 1 on completion, so rsp_err = 1 and rsp_timeout = 0. A following read of 0x10 gives rsp_rdata = 0 and rsp_err = 1.
- Wait states: slave holds pready = 0 for 3 ACCESS cycles on a read of 0x2 -> paddr = 0x2 and pwrite = 0 stay stable for 4 ACCESS cycles; rsp_valid appears 6 cycles after accept.
- Timeout: slave never asserts pready, with TIMEOUT = 16 -> ACCESS lasts exactly 16 cycles; then rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, and psel = 0.
- Backpressure and mid-transfer reset: hold rsp_ready = 0 for 5 cycles -> rsp_valid and its data stay constant and cmd_ready = 0. Separately, assert preset for 1 cycle during ACCESS -> psel and penable are 0 on the next edge, and the FSM is in IDLE with no response produced.
